// File: rtl/mandel_pkg.sv
// Shared types, fixed-point constants and arithmetic helpers for the Mandelbrot engine.
// Constants are stored at MANDEL_FRAC alignment; fx_realign moves them to any other alignment.
package mandel_pkg;

  localparam int MANDEL_W    = 27;
  localparam int MANDEL_FRAC = 23;
  localparam int MUL_W       = 64;

  typedef logic signed [MANDEL_W-1:0] fix_t;
  typedef logic signed [MUL_W-1:0]    wide_t;

  localparam wide_t FOUR      = 64'sd4 <<< MANDEL_FRAC;
  localparam wide_t QUARTER   = 64'sd1 <<< (MANDEL_FRAC - 2);
  localparam wide_t SIXTEENTH = 64'sd1 <<< (MANDEL_FRAC - 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } mandel_state_e;

  function automatic wide_t fx_mul_align(input wide_t a, input wide_t b, input int unsigned frac);
    wide_t prod;
    prod = a * b;
    return prod >>> frac;
  endfunction

  function automatic wide_t fx_realign(input wide_t v, input int unsigned from_frac,
                                       input int unsigned to_frac);
    wide_t r;
    if (to_frac >= from_frac) begin
      r = v <<< (to_frac - from_frac);
    end else begin
      r = v >>> (from_frac - to_frac);
    end
    return r;
  endfunction

endpackage

// File: rtl/mandel_cardioid_check.sv
// Two-stage interior test: stage 1 registers xq, q, b and ci^2 from c; stage 2 compares
// against the main-cardioid and period-2-bulb bounds. Only built with MANDEL_CARDIOID_EN.
module mandel_cardioid_check
  import mandel_pkg::*;
#(
  parameter int W    = 27,
  parameter int FRAC = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] c_r,
  input  logic [W-1:0] c_i,
  output logic         interior
);

  localparam wide_t QUARTER_F   = fx_realign(QUARTER, MANDEL_FRAC, FRAC);
  localparam wide_t ONE_F       = QUARTER_F <<< 2;
  localparam wide_t SIXTEENTH_F = fx_realign(SIXTEENTH, MANDEL_FRAC, FRAC);

  wide_t cr_w, ci_w, crp1_s;
  wide_t xq_d, q_d, b_d, ci2_d;
  wide_t xq_q, q_q, b_q, ci2_q;
  wide_t lhs_s;

  // ci^2 stays at double alignment so the cardioid bound keeps full precision
  always_comb begin
    cr_w   = {{(MUL_W-W){c_r[W-1]}}, c_r};
    ci_w   = {{(MUL_W-W){c_i[W-1]}}, c_i};
    crp1_s = cr_w + ONE_F;
    ci2_d  = fx_mul_align(ci_w, ci_w, 32'd0);
    xq_d   = cr_w - QUARTER_F;
    q_d    = fx_mul_align(xq_d, xq_d, FRAC) + (ci2_d >>> FRAC);
    b_d    = fx_mul_align(crp1_s, crp1_s, FRAC) + (ci2_d >>> FRAC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xq_q  <= 64'sd0;
      q_q   <= 64'sd0;
      b_q   <= 64'sd0;
      ci2_q <= 64'sd0;
    end else begin
      xq_q  <= xq_d;
      q_q   <= q_d;
      b_q   <= b_d;
      ci2_q <= ci2_d;
    end
  end

  always_comb begin
    lhs_s    = fx_mul_align(q_q, q_q + xq_q, 32'd0);
    interior = (lhs_s < (ci2_q >>> 2)) || (b_q < SIXTEENTH_F);
  end

endmodule

// File: rtl/mandel_iterator.sv
// Mandelbrot escape-time engine: iterates z <- z^2 + c for one point at a time.
// Define MANDEL_CARDIOID_EN to add a two-cycle cardioid/bulb early-out before iterating.
module mandel_iterator
  import mandel_pkg::*;
#(
  parameter int W      = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 11,
  parameter int TAG_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [W-1:0]      in_c_r,
  input  logic [W-1:0]      in_c_i,
  input  logic [ITER_W-1:0] in_max_iter,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_val,
  input  logic              out_rdy
);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_CHECK = S_CHECK;
  localparam logic [1:0] ST_ITER  = S_ITER;
  localparam logic [1:0] ST_DONE  = S_DONE;
  localparam wide_t FOUR_FULL = fx_realign(FOUR, MANDEL_FRAC, 2 * FRAC);

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
  logic [ITER_W-1:0] n_q, n_d, max_q, max_d, count_q, count_d;
  logic [TAG_W-1:0]  tag_q, tag_d, otag_q, otag_d;
  logic              esc_q, esc_d, out_val_q, out_val_d, in_rdy_q, in_rdy_d;

  wide_t zr_w, zi_w, cr_w, ci_w;
  wide_t zr2_full, zi2_full, zri, zr_nx, zi_nx;
  logic  escape_s;
  logic  unused_bits_s;

  assign zr_w = {{(MUL_W-W){zr_q[W-1]}}, zr_q};
  assign zi_w = {{(MUL_W-W){zi_q[W-1]}}, zi_q};
  assign cr_w = {{(MUL_W-W){cr_q[W-1]}}, cr_q};
  assign ci_w = {{(MUL_W-W){ci_q[W-1]}}, ci_q};

  // Escape compare uses the unaligned products so no fraction bits are lost
  assign zr2_full = fx_mul_align(zr_w, zr_w, 32'd0);
  assign zi2_full = fx_mul_align(zi_w, zi_w, 32'd0);
  assign zri      = fx_mul_align(zr_w, zi_w, FRAC);
  assign escape_s = (zr2_full + zi2_full) > FOUR_FULL;
  assign zr_nx    = (zr2_full >>> FRAC) - (zi2_full >>> FRAC) + cr_w;
  assign zi_nx    = (zri <<< 1) + ci_w;
  assign unused_bits_s = ^{zr_nx[MUL_W-1:W], zi_nx[MUL_W-1:W]};

`ifdef MANDEL_CARDIOID_EN
  logic chk_phase_q, chk_phase_d;
  logic interior_s;

  mandel_cardioid_check #(.W(W), .FRAC(FRAC)) u_check (
    .clk      (clk),
    .reset    (reset),
    .c_r      (cr_q),
    .c_i      (ci_q),
    .interior (interior_s)
  );

  // CHECK phase: first cycle fills the check pipeline, second cycle reads its verdict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_phase_q <= 1'b0;
    end else begin
      chk_phase_q <= chk_phase_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    n_d     = n_q;
    max_d   = max_q;
    tag_d   = tag_q;
    count_d = count_q;
    esc_d   = esc_q;
    otag_d  = otag_q;
`ifdef MANDEL_CARDIOID_EN
    chk_phase_d = chk_phase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_val) begin
          cr_d  = in_c_r;
          ci_d  = in_c_i;
          max_d = in_max_iter;
          tag_d = in_tag;
          zr_d  = {W{1'b0}};
          zi_d  = {W{1'b0}};
          n_d   = {ITER_W{1'b0}};
`ifdef MANDEL_CARDIOID_EN
          chk_phase_d = 1'b0;
          state_d     = ST_CHECK;
`else
          state_d = ST_ITER;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
`ifdef MANDEL_CARDIOID_EN
        if (!chk_phase_q) begin
          chk_phase_d = 1'b1;
        end else if (interior_s) begin
          count_d = max_q;
          esc_d   = 1'b0;
          otag_d  = tag_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ITER: begin
        if (escape_s) begin
          count_d = n_q;
          esc_d   = 1'b1;
          otag_d  = tag_q;
          state_d = ST_DONE;
        end else if (n_q == max_q) begin
          count_d = max_q;
          esc_d   = 1'b0;
          otag_d  = tag_q;
          state_d = ST_DONE;
        end else begin
          zr_d = zr_nx[W-1:0];
          zi_d = zi_nx[W-1:0];
          n_d  = n_q + ITER_W'(1'b1);
        end
      end
      ST_DONE: begin
        if (out_rdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_val_d = (state_d == ST_DONE);
    in_rdy_d  = (state_d == ST_IDLE);
  end

  // Main state, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cr_q      <= {W{1'b0}};
      ci_q      <= {W{1'b0}};
      zr_q      <= {W{1'b0}};
      zi_q      <= {W{1'b0}};
      n_q       <= {ITER_W{1'b0}};
      max_q     <= {ITER_W{1'b0}};
      tag_q     <= {TAG_W{1'b0}};
      count_q   <= {ITER_W{1'b0}};
      esc_q     <= 1'b0;
      otag_q    <= {TAG_W{1'b0}};
      out_val_q <= 1'b0;
      in_rdy_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cr_q      <= cr_d;
      ci_q      <= ci_d;
      zr_q      <= zr_d;
      zi_q      <= zi_d;
      n_q       <= n_d;
      max_q     <= max_d;
      tag_q     <= tag_d;
      count_q   <= count_d;
      esc_q     <= esc_d;
      otag_q    <= otag_d;
      out_val_q <= out_val_d;
      in_rdy_q  <= in_rdy_d;
    end
  end

  assign in_rdy     = in_rdy_q;
  assign out_val    = out_val_q;
  assign iter_count = count_q;
  assign escaped    = esc_q;
  assign out_tag    = otag_q;

endmodule
